line_fetch_unit: RTL

- Responder end of the cache fetch interface. Accepts one fetch command at a time from the cache read/write controllers.
- A fill moves one line from the external memory bus into the cache data memory. A writeback moves one line from the cache data memory out to the external bus.
- Signals completion on fetch_done. Sits between the controller fetch ports, the cache data memory, and the external memory bus.

---
 rtl/line_fetch_unit.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/line_fetch_unit.sv
// Line fetch unit: services one fill or writeback command at a time, moving a
// whole cache line between the external memory bus and the cache data memory.
//
// state    | meaning
// IDLE     | waiting for fetch_req; grant is combinational
// RD_ADDR  | fill: bus read address offered
// RD_DATA  | fill: bus beats pass through a one-word buffer into cache memory
// WB_ADDR  | writeback: bus write address offered
// WB_MRD   | writeback: single-word read request to cache memory
// WB_MWAIT | writeback: waiting for the cache memory read data
// WB_WDATA | writeback: captured word offered on the bus
// WB_RESP  | writeback: waiting for the bus write response
// DONE     | one-cycle fetch_done pulse
module line_fetch_unit #(
    parameter int addr_width = 32,
    parameter int data_width = 32,
    parameter int list_depth = 4,
    parameter int list_width = 32
) (
    input  logic                                             clk,
    input  logic                                             rst_n,
    input  logic                                             fetch_req,
    input  logic [1:0]                                       fetch_cmd,
    input  logic [$clog2(list_depth)-1:0]                    fetch_tag,
    input  logic [addr_width-1:0]                            fetch_addr,
    output logic                                             fetch_gnt,
    output logic                                             fetch_done,
    output logic [$clog2(list_depth)+$clog2(list_width)-1:0] mem_waddr,
    output logic                                             mem_wen,
    output logic [data_width-1:0]                            mem_wdata,
    input  logic                                             mem_wready,
    output logic [$clog2(list_depth)+$clog2(list_width)-1:0] mem_raddr,
    output logic                                             mem_ren,
    input  logic                                             mem_rready,
    input  logic [data_width-1:0]                            mem_rdata,
    input  logic                                             mem_rdata_valid,
    output logic                                             ext_arvalid,
    input  logic                                             ext_arready,
    output logic [addr_width-1:0]                            ext_araddr,
    input  logic                                             ext_rvalid,
    output logic                                             ext_rready,
    input  logic [data_width-1:0]                            ext_rdata,
    output logic                                             ext_awvalid,
    input  logic                                             ext_awready,
    output logic [addr_width-1:0]                            ext_awaddr,
    output logic                                             ext_wvalid,
    input  logic                                             ext_wready,
    output logic [data_width-1:0]                            ext_wdata,
    input  logic                                             ext_bvalid,
    output logic                                             ext_bready
);

    localparam int tag_w  = $clog2(list_depth);
    localparam int word_w = $clog2(list_width);
    localparam int off_w  = $clog2(list_width * data_width / 8);
    localparam logic [word_w-1:0]     last_word = word_w'(list_width - 1);
    localparam logic [addr_width-1:0] off_mask  = addr_width'((64'd1 << off_w) - 64'd1);

    typedef enum logic [3:0] {
        IDLE, RD_ADDR, RD_DATA, WB_ADDR, WB_MRD, WB_MWAIT, WB_WDATA, WB_RESP, DONE
    } state_t;

    state_t                 state_q, state_d;
    logic [tag_w-1:0]       tag_q, tag_d;
    logic [addr_width-1:0]  addr_q, addr_d;
    logic [word_w-1:0]      w_q, w_d;
    logic [data_width-1:0]  buf_q, buf_d;
    logic                   buf_valid_q, buf_valid_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            tag_q       <= '0;
            addr_q      <= '0;
            w_q         <= '0;
            buf_q       <= '0;
            buf_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            tag_q       <= tag_d;
            addr_q      <= addr_d;
            w_q         <= w_d;
            buf_q       <= buf_d;
            buf_valid_q <= buf_valid_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        tag_d       = tag_q;
        addr_d      = addr_q;
        w_d         = w_q;
        buf_d       = buf_q;
        buf_valid_d = buf_valid_q;
        fetch_gnt   = 1'b0;
        fetch_done  = 1'b0;
        mem_wen     = 1'b0;
        mem_ren     = 1'b0;
        ext_arvalid = 1'b0;
        ext_rready  = 1'b0;
        ext_awvalid = 1'b0;
        ext_wvalid  = 1'b0;
        ext_bready  = 1'b0;

        case (state_q)
            IDLE: begin
                if (fetch_req) begin
                    fetch_gnt   = 1'b1;
                    tag_d       = fetch_tag;
                    addr_d      = fetch_addr & ~off_mask;
                    w_d         = '0;
                    buf_valid_d = 1'b0;
                    case (fetch_cmd)
                        2'b01:   state_d = RD_ADDR;
                        2'b00:   state_d = WB_ADDR;
                        default: state_d = DONE;
                    endcase
                end
            end
            RD_ADDR: begin
                ext_arvalid = 1'b1;
                if (ext_arready) state_d = RD_DATA;
            end
            RD_DATA: begin
                ext_rready = !buf_valid_q;
                mem_wen    = buf_valid_q;
                // The beat count, not the bus, decides when the line is complete.
                if (mem_wen && mem_wready) begin
                    buf_valid_d = 1'b0;
                    if (w_q == last_word) state_d = DONE;
                    else                  w_d = w_q + word_w'(1);
                end
                if (ext_rvalid && ext_rready) begin
                    buf_valid_d = 1'b1;
                    buf_d       = ext_rdata;
                end
            end
            WB_ADDR: begin
                ext_awvalid = 1'b1;
                if (ext_awready) state_d = WB_MRD;
            end
            WB_MRD: begin
                mem_ren = 1'b1;
                if (mem_rready) state_d = WB_MWAIT;
            end
            WB_MWAIT: begin
                if (mem_rdata_valid) begin
                    buf_d   = mem_rdata;
                    state_d = WB_WDATA;
                end
            end
            WB_WDATA: begin
                ext_wvalid = 1'b1;
                if (ext_wready) begin
                    if (w_q == last_word) begin
                        state_d = WB_RESP;
                    end else begin
                        w_d     = w_q + word_w'(1);
                        state_d = WB_MRD;
                    end
                end
            end
            WB_RESP: begin
                ext_bready = 1'b1;
                if (ext_bvalid) state_d = DONE;
            end
            DONE: begin
                fetch_done = 1'b1;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign mem_waddr  = {tag_q, w_q};
    assign mem_raddr  = {tag_q, w_q};
    assign mem_wdata  = buf_q;
    assign ext_wdata  = buf_q;
    assign ext_araddr = addr_q;
    assign ext_awaddr = addr_q;

endmodule
